// File: rtl/conv_top.sv
// conv_top: 3x3x3 window convolution against K_NUM kernels.
// Three-stage pipeline: multiply, reduce, shift and saturate.
module conv_top #(
    parameter int IF_BITWIDTH = 16,
    parameter int IF_PORT     = 27,
    parameter int K_BITWIDTH  = 8,
    parameter int K_FRAC_BIT  = 6,
    parameter int K_NUM       = 3,
    parameter int OF_WIDTH    = 128,
    parameter int OF_HEIGHT   = 128,
    parameter int OF_BITWIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             if_start,
    input  logic                             k_prefetch,
    output logic                             of_done,
    input  logic [IF_PORT*IF_BITWIDTH-1:0]   if_i_data,
    input  logic [IF_PORT-1:0]               if_i_valid,
    input  logic [K_NUM*K_BITWIDTH-1:0]      k_i_data,
    input  logic [K_NUM-1:0]                 k_i_valid,
    output logic [K_NUM*OF_BITWIDTH-1:0]     of_o_data,
    output logic [K_NUM-1:0]                 of_o_valid
);

    localparam int PW   = IF_BITWIDTH + K_BITWIDTH;
    localparam int AW   = PW + $clog2(IF_PORT);
    localparam int NPIX = OF_WIDTH * OF_HEIGHT;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int KCW  = $clog2(IF_PORT + 1);

    localparam logic [CW-1:0]  NPIX_C = CW'(NPIX);
    localparam logic [CW-1:0]  LAST_C = CW'(NPIX - 1);
    localparam logic [KCW-1:0] KFULL  = KCW'(IF_PORT);

    typedef enum logic [1:0] {IDLE, KLOAD, RUN} state_t;

    state_t                        state;
    logic signed [K_BITWIDTH-1:0]  weight [K_NUM][IF_PORT];
    logic [KCW-1:0]                kcnt   [K_NUM];
    logic [CW-1:0]                 in_cnt;
    logic [CW-1:0]                 out_cnt;
    logic                          kload_done;
    logic                          accept;

    logic signed [PW-1:0]          prod  [K_NUM][IF_PORT];
    logic signed [AW-1:0]          sum   [K_NUM];
    logic signed [AW-1:0]          sum_c [K_NUM];
    logic                          v1;
    logic                          v2;

    assign accept = (state == RUN) && (&if_i_valid) && (in_cnt < NPIX_C);

    always_comb begin
        kload_done = 1'b1;
        for (int j = 0; j < K_NUM; j++)
            if (kcnt[j] != KFULL) kload_done = 1'b0;
    end

    always_comb begin
        for (int j = 0; j < K_NUM; j++) begin
            sum_c[j] = '0;
            for (int n = 0; n < IF_PORT; n++)
                sum_c[j] = sum_c[j] + $signed({{(AW-PW){prod[j][n][PW-1]}}, prod[j][n]});
        end
    end

    // Floor shift back to the output format, then clamp anything that
    // no longer fits in OF_BITWIDTH signed bits.
    function automatic logic [OF_BITWIDTH-1:0] sat(input logic signed [AW-1:0] s);
        logic signed [AW-1:0]           t;
        logic        [AW-OF_BITWIDTH:0] hi;
        t  = s >>> K_FRAC_BIT;
        hi = t[AW-1:OF_BITWIDTH-1];
        if ((&hi) || (~|hi))
            return t[OF_BITWIDTH-1:0];
        else if (t[AW-1])
            return {1'b1, {(OF_BITWIDTH-1){1'b0}}};
        else
            return {1'b0, {(OF_BITWIDTH-1){1'b1}}};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            in_cnt  <= '0;
            out_cnt <= '0;
            of_done <= 1'b0;
            for (int j = 0; j < K_NUM; j++) begin
                kcnt[j] <= '0;
                for (int n = 0; n < IF_PORT; n++)
                    weight[j][n] <= '0;
            end
        end else begin
            of_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (k_prefetch) begin
                        state <= KLOAD;
                        for (int j = 0; j < K_NUM; j++)
                            kcnt[j] <= '0;
                    end else if (if_start) begin
                        state   <= RUN;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                KLOAD: begin
                    for (int j = 0; j < K_NUM; j++) begin
                        if (k_i_valid[j] && kcnt[j] < KFULL) begin
                            weight[j][kcnt[j]] <= k_i_data[j*K_BITWIDTH +: K_BITWIDTH];
                            kcnt[j]            <= kcnt[j] + 1'b1;
                        end
                    end
                    if (kload_done) state <= IDLE;
                end
                RUN: begin
                    if (accept) in_cnt <= in_cnt + 1'b1;
                    if (of_o_valid[0]) begin
                        if (out_cnt == LAST_C) begin
                            of_done <= 1'b1;
                            out_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            of_o_valid <= '0;
            of_o_data  <= '0;
            for (int j = 0; j < K_NUM; j++) begin
                sum[j] <= '0;
                for (int n = 0; n < IF_PORT; n++)
                    prod[j][n] <= '0;
            end
        end else begin
            v1         <= accept;
            v2         <= v1;
            of_o_valid <= {K_NUM{v2}};
            if (accept) begin
                for (int j = 0; j < K_NUM; j++)
                    for (int n = 0; n < IF_PORT; n++)
                        prod[j][n] <= $signed(if_i_data[n*IF_BITWIDTH +: IF_BITWIDTH])
                                      * weight[j][n];
            end
            if (v1) begin
                for (int j = 0; j < K_NUM; j++)
                    sum[j] <= sum_c[j];
            end
            if (v2) begin
                for (int j = 0; j < K_NUM; j++)
                    of_o_data[j*OF_BITWIDTH +: OF_BITWIDTH] <= sat(sum[j]);
            end
        end
    end

endmodule

// File: tb/tb_conv_top.sv
// Bench for conv_top on a 4x4 output plane: vector table of
// constant-window passes plus random, reset and repeat-pass sequences.
module tb_conv_top;

    localparam int NPIX = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         if_start = 1'b0;
    logic         k_prefetch = 1'b0;
    logic         of_done;
    logic [431:0] if_i_data = '0;
    logic [26:0]  if_i_valid = '0;
    logic [23:0]  k_i_data = '0;
    logic [2:0]   k_i_valid = '0;
    logic [47:0]  of_o_data;
    logic [2:0]   of_o_valid;

    conv_top #(.OF_WIDTH(4), .OF_HEIGHT(4)) dut (
        .clk(clk), .rst(rst), .if_start(if_start), .k_prefetch(k_prefetch),
        .of_done(of_done), .if_i_data(if_i_data), .if_i_valid(if_i_valid),
        .k_i_data(k_i_data), .k_i_valid(k_i_valid),
        .of_o_data(of_o_data), .of_o_valid(of_o_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]      ifv;
        logic [2:0][7:0]  w;
        logic [2:0][15:0] ex;
    } vec_t;

    typedef struct {
        logic [2:0][15:0] data;
        int               cyc;
    } exp_t;

    exp_t              exp_q [$];
    vec_t              tbl [6];
    logic signed [7:0] w_model [3][27];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int out_seen = 0;
    bit prev_valid = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic vec_t mk(input int ifv, input int w0, input int w1, input int w2,
                                input int e0, input int e1, input int e2);
        vec_t v;
        v.ifv = 16'(ifv);
        v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2);
        v.ex[0] = 16'(e0); v.ex[1] = 16'(e1); v.ex[2] = 16'(e2);
        return v;
    endfunction

    function automatic logic signed [15:0] model(input logic signed [15:0] win [27], input int j);
        longint acc = 0;
        for (int n = 0; n < 27; n++)
            acc += longint'(win[n]) * longint'(w_model[j][n]);
        acc = acc >>> 6;
        if (acc > 32767) return 16'h7fff;
        if (acc < -32768) return 16'h8000;
        return 16'(acc);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (of_done) begin
                done_cnt++;
                chk("done_after_last_valid", prev_valid, 1);
            end
            if (|of_o_valid) begin
                out_seen++;
                chk("valid_together", of_o_valid, 3'b111);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_output: got data %h, expected no output", of_o_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    for (int j = 0; j < 3; j++)
                        chk($sformatf("plane%0d", j), $signed(of_o_data[j*16 +: 16]),
                            $signed(e.data[j]));
                    chk("latency", cyc - e.cyc, 3);
                end
            end
            prev_valid = &of_o_valid;
        end
    end

    task automatic load_weights();
        int idx [3];
        idx = '{0, 0, 0};
        k_prefetch = 1'b1;
        @(posedge clk); #1;
        k_prefetch = 1'b0;
        while (idx[0] < 27 || idx[1] < 27 || idx[2] < 27) begin
            k_i_valid = '0;
            for (int j = 0; j < 3; j++) begin
                if (idx[j] < 27 && $urandom_range(0, 3) != 0) begin
                    k_i_valid[j] = 1'b1;
                    k_i_data[j*8 +: 8] = w_model[j][idx[j]];
                    idx[j]++;
                end
            end
            @(posedge clk); #1;
        end
        k_i_valid = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int kind, input logic [15:0] cval,
                              input logic [2:0][15:0] cexp, input bit push);
        logic signed [15:0] win [27];
        exp_t e;
        for (int n = 0; n < 27; n++) begin
            win[n] = (kind == 0) ? cval : 16'($urandom_range(0, 4095)) - 16'd2048;
            if_i_data[n*16 +: 16] = win[n];
        end
        if_i_valid = '1;
        if (push) begin
            e.cyc = cyc;
            if (kind == 0) e.data = cexp;
            else for (int j = 0; j < 3; j++) e.data[j] = model(win, j);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_pass(input string name, input int kind, input logic [15:0] cval,
                            input logic [2:0][15:0] cexp, input int extra, input bit noisy);
        int d0;
        int pushed;
        int budget;
        d0 = done_cnt;
        pushed = 0;
        if_start = 1'b1;
        @(posedge clk); #1;
        if_start = 1'b0;
        while (pushed < NPIX + extra) begin
            if (noisy && $urandom_range(0, 3) == 0) begin
                if_i_valid = 27'($urandom) & ~(27'd1 << $urandom_range(0, 26));
                for (int n = 0; n < 27; n++) if_i_data[n*16 +: 16] = 16'($urandom);
                @(posedge clk); #1;
            end else if (noisy && $urandom_range(0, 3) == 0) begin
                if_i_valid = '0;
                @(posedge clk); #1;
            end else begin
                drive_beat(kind, cval, cexp, pushed < NPIX);
                pushed++;
            end
        end
        if_i_valid = '0;
        budget = 0;
        while (done_cnt == d0 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [2:0][15:0] zero3;
        int out0;
        int d0;
        int guard;
        zero3 = '0;
        tbl[0] = mk(256,    64,  -64,    0,   6912,  -6912,     0);
        tbl[1] = mk(32767, 127,  127,  127,  32767,  32767, 32767);
        tbl[2] = mk(32767, -128, -128, -128, -32768, -32768, -32768);
        tbl[3] = mk(1,       1,   -1,    0,      0,     -1,     0);
        tbl[4] = mk(100,     3,   -3,   64,    126,   -127,  2700);
        tbl[5] = mk(-256,   64,  127, -128,  -6912, -13716, 13824);
        for (int j = 0; j < 3; j++)
            for (int n = 0; n < 27; n++) w_model[j][n] = '0;

        #1;
        chk("reset_valid", of_o_valid, 0);
        chk("reset_data", of_o_data, 0);
        chk("reset_done", of_done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_pass("no_kload", 1, '0, zero3, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 3; j++)
                for (int n = 0; n < 27; n++) w_model[j][n] = tbl[r].w[j];
            load_weights();
            run_pass($sformatf("row%0d", r), 0, tbl[r].ifv, tbl[r].ex, 0, r[0]);
        end

        for (int j = 0; j < 3; j++)
            for (int n = 0; n < 27; n++) w_model[j][n] = 8'($urandom);
        load_weights();
        run_pass("rand_excess", 1, '0, zero3, 4, 1'b1);
        run_pass("rand_repeat", 1, '0, zero3, 0, 1'b0);

        for (int j = 0; j < 3; j++)
            for (int n = 0; n < 27; n++) w_model[j][n] = 8'($urandom);
        load_weights();
        out0 = out_seen;
        d0 = done_cnt;
        guard = 0;
        if_start = 1'b1;
        @(posedge clk); #1;
        if_start = 1'b0;
        while (out_seen - out0 < 5 && guard < 40) begin
            drive_beat(1, '0, zero3, 1'b1);
            guard++;
        end
        chk("midpass_outputs_seen", out_seen - out0, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_valid", of_o_valid, 0);
        chk("midreset_data", of_o_data, 0);
        chk("midreset_done", of_done, 0);
        if_i_valid = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_no_done", done_cnt - d0, 0);

        for (int j = 0; j < 3; j++)
            for (int n = 0; n < 27; n++) w_model[j][n] = '0;
        run_pass("post_reset_zero_w", 1, '0, zero3, 0, 1'b0);
        for (int j = 0; j < 3; j++)
            for (int n = 0; n < 27; n++) w_model[j][n] = 8'($urandom);
        load_weights();
        run_pass("post_reset_fresh", 1, '0, zero3, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
